axi3_mem_responder: RTL and testbench
=====================================

// Module: axi3_mem_responder
// PURPOSE
//  AXI3 slave (responder) backed by an on-chip word array. Serves the single-beat and INCR-burst
//  traffic that the cache issues on one memory port (data or instruction).
//  Used for simulation and for FPGA builds without external DRAM; instantiate one per cache port.
//  Read and write channels are independent and may run concurrently.
// PARAMETERS
//  BIT_WIDTH    32  data width, fixed at 32; WSTRB_WIDTH = BIT_WIDTH/8
//  ADDR_WIDTH   12  log2 of word count (12 -> 4096 words, 16 KiB)
//  BASE_ADDR    0   byte base; in range iff addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]
//  RD_LATENCY   1   cycles from AR handshake to first rvalid, >= 1
// PORTS
//  clk                                   in   1   clock, all logic on posedge
//  rst                                   in   1   synchronous active-high reset
//  mem_awvalid / mem_awready             in/out  1/1   write address handshake
//  mem_awaddr, mem_awlen                 in   32, 8   start byte address; beats-1
//  mem_awsize, mem_awburst               in   3, 2    must be 3'b010 and 2'b01 (INCR)
//  mem_wvalid / mem_wready               in/out  1/1   write data handshake
//  mem_wdata, mem_wstrb, mem_wlast       in   32, 4, 1   data, byte enables, last beat
//  mem_bvalid / mem_bready, mem_bresp    out/in/out  1/1/2   write response
//  mem_arvalid / mem_arready             in/out  1/1   read address handshake
//  mem_araddr, mem_arlen, mem_arsize, mem_arburst   in   32/8/3/2   same rules as AW
//  mem_rvalid / mem_rready               out/in  1/1   read data handshake
//  mem_rdata, mem_rresp, mem_rlast       out  32, 2, 1   read beat, response, last beat
// BEHAVIOUR
//  Reset
//   - all valid and ready outputs are 0; bresp, rresp, rdata and rlast are 0.
//   - both FSMs return to IDLE. Array contents are not reset.
//  Word index and wrap
//   - word index = addr[ADDR_WIDTH+1:2]; it increments by 1 per beat.
//   - the index wraps modulo 2^ADDR_WIDTH.
//  Burst check (per burst, evaluated at the address handshake)
//   - DECERR 2'b11: address out of range.
//   - SLVERR 2'b10: otherwise, if size != 2, burst != INCR, or len > 15.
//   - OKAY 2'b00: otherwise.
//   - DECERR takes priority. An errored burst does no array writes, and its reads return 0.
//  Write FSM
//   - W_IDLE: awready=1. On handshake, latch index, len and error; go to W_DATA.
//   - W_DATA: wready=1, awready=0. Each W handshake writes the bytes enabled by wstrb (if OKAY),
//     then increments the index and the beat count. Go to W_RESP after beat len+1.
//   - The burst ends on the beat count; wlast is not used to end it.
//   - A wlast mismatch (wlast missing on the final beat, or asserted early) forces SLVERR. Writes
//     already made are kept.
//   - W_RESP: bvalid=1 with bresp held stable until bready; then go to W_IDLE.
//   - W beats presented before the AW handshake are not accepted: wready stays 0.
//   - AW handshake to wready=1: 1 cycle. Last W handshake to bvalid=1: 1 cycle.
//  Read FSM
//   - R_IDLE: arready=1. On handshake, latch index, len and error; go to R_WAIT.
//   - R_WAIT: RD_LATENCY-1 cycles, then R_DATA. With RD_LATENCY=1, go straight to R_DATA; first
//     rvalid is the cycle after the AR handshake.
//   - R_DATA: rvalid=1. rdata = array[index], or 0 on error; rresp = latched response;
//     rlast=1 only on beat len+1.
//   - While rvalid=1 and rready=0: rdata, rresp and rlast hold stable.
//   - With rready held high, beats go back-to-back, one per cycle.
//   - Handshake on the last beat: go to R_IDLE; rvalid=0 the next cycle.
//  Concurrent read and write to the same word
//   - a read beat presented in the cycle after a W handshake returns the new data.
//   - a read beat presented in the same cycle returns the old data.
//  Reset mid-burst
//   - rvalid, bvalid, wready and awready drop the next cycle; the burst is abandoned.
//   - words already written remain.
// TESTING
//  1. AW 0x10 len 0, W 0xDEADBEEF strb F, then AR 0x10 -> bresp 00; rdata 0xDEADBEEF, rlast 1;
//     rvalid RD_LATENCY cycles after AR.
//  2. Write strb 4'b0010 data 0x0000AB00 to word holding 0xDEADBEEF -> read returns 0xDEADABEF.
//  3. Burst write 0x100 len 3 data 1,2,3,4; burst read with rready toggling -> beats 1,2,3,4;
//     rlast on beat 4 only; outputs stable while stalled.
//  4. AW/AR at BASE+2^(ADDR_WIDTH+2) -> bresp 11; rresp 11 with rdata 0; memory unchanged.
//     awsize=1 -> bresp 10.
//  5. bready low for 5 cycles -> bvalid and bresp held, awready 0; a concurrent 4-beat read
//     completes meanwhile.
//  6. rst pulsed on beat 3 of an 8-beat read -> rvalid 0 next cycle, arready 1; next read correct.

Source files
------------

// File: rtl/axi3_mem_responder.sv
// -----------------------------------------------------------------------------
// axi3_mem_responder
//   AXI3 slave backed by an on-chip word array. It serves single-beat and INCR
//   burst traffic from one cache memory port. The read and write channels are
//   independent and may run at the same time.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   mem_aw*  (valid/ready/addr/len/size/burst)   write address channel
//   mem_w*   (valid/ready/data/strb/last)        write data channel
//   mem_b*   (valid/ready/resp)                  write response channel
//   mem_ar*  (valid/ready/addr/len/size/burst)   read address channel
//   mem_r*   (valid/ready/data/resp/last)        read data channel
//
// Word index = addr[ADDR_WIDTH+1:2]. It advances by one per beat and wraps
// modulo 2^ADDR_WIDTH. The burst response is decided at the address handshake:
// DECERR for an out-of-range address, else SLVERR for an unsupported
// size/burst/len, else OKAY. Errored bursts never touch the array, and their
// read beats return zero.
// -----------------------------------------------------------------------------
module axi3_mem_responder #(
   parameter int          BIT_WIDTH  = 32,
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RD_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_awvalid,
   output logic                   mem_awready,
   input  logic [31:0]            mem_awaddr,
   input  logic [7:0]             mem_awlen,
   input  logic [2:0]             mem_awsize,
   input  logic [1:0]             mem_awburst,
   input  logic                   mem_wvalid,
   output logic                   mem_wready,
   input  logic [BIT_WIDTH-1:0]   mem_wdata,
   input  logic [BIT_WIDTH/8-1:0] mem_wstrb,
   input  logic                   mem_wlast,
   output logic                   mem_bvalid,
   input  logic                   mem_bready,
   output logic [1:0]             mem_bresp,
   input  logic                   mem_arvalid,
   output logic                   mem_arready,
   input  logic [31:0]            mem_araddr,
   input  logic [7:0]             mem_arlen,
   input  logic [2:0]             mem_arsize,
   input  logic [1:0]             mem_arburst,
   output logic                   mem_rvalid,
   input  logic                   mem_rready,
   output logic [BIT_WIDTH-1:0]   mem_rdata,
   output logic [1:0]             mem_rresp,
   output logic                   mem_rlast
);

   localparam int         STRB_WIDTH = BIT_WIDTH / 8;
   localparam int         DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_SLV   = 2'b10;
   localparam logic [1:0] RESP_DEC   = 2'b11;
   localparam logic [7:0] WAIT_INIT  = 8'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   function automatic logic [1:0] f_burst_check(input logic [31:0] addr,
                                                input logic [7:0]  len,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
      if (addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) return RESP_DEC;
      if (size != 3'b010 || burst != 2'b01 || len > 8'd15)     return RESP_SLV;
      return RESP_OKAY;
   endfunction

   // NOTE: the array has no reset; clearing thousands of words would need a
   // reset fan-out to every entry and would stop the array mapping onto RAM.
   logic [BIT_WIDTH-1:0]  r_mem [0:DEPTH-1];

   // ---------------------------------------------------------------- write --
   w_state_t              r_w_state, w_w_next;
   logic                  r_awready, r_wready, r_bvalid;
   logic [ADDR_WIDTH-1:0] r_w_idx;
   logic [8:0]            r_w_left;      // beats still to accept
   logic [1:0]            r_w_resp;
   logic                  w_aw_hs, w_w_hs, w_b_hs, w_w_we, w_w_final;

   assign w_aw_hs   = mem_awvalid & r_awready;
   assign w_w_hs    = mem_wvalid & r_wready;
   assign w_b_hs    = r_bvalid & mem_bready;
   assign w_w_final = (r_w_left == 9'd1);
   assign w_w_we    = w_w_hs && (r_w_resp == RESP_OKAY);

   // NOTE: every combinational output gets a default before the case so that
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_w_next = r_w_state;
      unique case (r_w_state)
         W_IDLE:  if (w_aw_hs)               w_w_next = W_DATA;
         W_DATA:  if (w_w_hs && w_w_final)   w_w_next = W_RESP;
         W_RESP:  if (w_b_hs)                w_w_next = W_IDLE;
         default:                            w_w_next = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state, so they are 0
   // while rst is held and drop one cycle after a mid-burst reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_state <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_w_state <= w_w_next;
         r_awready <= (w_w_next == W_IDLE);
         r_wready  <= (w_w_next == W_DATA);
         r_bvalid  <= (w_w_next == W_RESP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_w_idx  <= '0;
         r_w_left <= '0;
         r_w_resp <= RESP_OKAY;
      end else if (w_aw_hs) begin
         r_w_idx  <= mem_awaddr[ADDR_WIDTH+1:2];
         r_w_left <= {1'b0, mem_awlen} + 9'd1;
         r_w_resp <= f_burst_check(mem_awaddr, mem_awlen, mem_awsize, mem_awburst);
      end else if (w_w_hs) begin
         r_w_idx  <= r_w_idx + 1'b1;
         r_w_left <= r_w_left - 9'd1;
         // The beat count ends the burst; wlast only flags a framing error.
         // Writes already made stay, and later beats of the burst are dropped.
         if (r_w_resp != RESP_DEC && mem_wlast != w_w_final) r_w_resp <= RESP_SLV;
      end
   end

   always_ff @(posedge clk) begin
      if (w_w_we) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (mem_wstrb[b]) r_mem[r_w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign mem_awready = r_awready;
   assign mem_wready  = r_wready;
   assign mem_bvalid  = r_bvalid;
   assign mem_bresp   = r_w_resp;

   // ----------------------------------------------------------------- read --
   r_state_t              r_r_state, w_r_next;
   logic                  r_arready, r_rvalid, r_rlast;
   logic [BIT_WIDTH-1:0]  r_rdata;
   logic [1:0]            r_rresp, r_r_resp;
   logic [ADDR_WIDTH-1:0] r_r_idx;       // index of the next beat to load
   logic [8:0]            r_r_left;      // beats still to load
   logic [7:0]            r_r_wait;
   logic                  w_ar_hs, w_r_hs, w_load;
   logic [1:0]            w_ar_resp, w_load_resp;
   logic [ADDR_WIDTH-1:0] w_load_idx;
   logic [8:0]            w_load_left;
   logic [BIT_WIDTH-1:0]  w_fwd_word;

   assign w_ar_hs   = mem_arvalid & r_arready;
   assign w_r_hs    = r_rvalid & mem_rready;
   assign w_ar_resp = f_burst_check(mem_araddr, mem_arlen, mem_arsize, mem_arburst);

   always_comb begin
      w_r_next = r_r_state;
      unique case (r_r_state)
         R_IDLE:  if (w_ar_hs) w_r_next = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
         R_WAIT:  if (r_r_wait == 8'd0) w_r_next = R_DATA;
         R_DATA:  if (w_r_hs && r_rlast) w_r_next = R_IDLE;
         default: w_r_next = R_IDLE;
      endcase
   end

   // A beat is loaded when R_DATA is entered or when the current beat is
   // accepted and another follows. With RD_LATENCY=1 the first load coincides
   // with the AR handshake, so its parameters come straight from the AR bus.
   assign w_load      = (w_r_next == R_DATA) && ((r_r_state != R_DATA) || w_r_hs);
   assign w_load_idx  = (r_r_state == R_IDLE) ? mem_araddr[ADDR_WIDTH+1:2] : r_r_idx;
   assign w_load_left = (r_r_state == R_IDLE) ? ({1'b0, mem_arlen} + 9'd1) : r_r_left;
   assign w_load_resp = (r_r_state == R_IDLE) ? w_ar_resp : r_r_resp;

   // A W beat committing on the same edge as this load is merged in, so a
   // read beat presented the cycle after a write already sees the new bytes.
   // NOTE: blocking assignments here build the value step by step within one
   // evaluation; sequential state always uses non-blocking assignments.
   always_comb begin
      w_fwd_word = r_mem[w_load_idx];
      if (w_w_we && (r_w_idx == w_load_idx)) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (mem_wstrb[b]) w_fwd_word[8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_r_state <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_r_state <= w_r_next;
         r_arready <= (w_r_next == R_IDLE);
         r_rvalid  <= (w_r_next == R_DATA);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_r_idx  <= '0;
         r_r_left <= '0;
         r_r_resp <= RESP_OKAY;
         r_r_wait <= '0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
         r_rlast  <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_r_idx  <= mem_araddr[ADDR_WIDTH+1:2];
            r_r_left <= {1'b0, mem_arlen} + 9'd1;
            r_r_resp <= w_ar_resp;
            r_r_wait <= WAIT_INIT;
         end else if (r_r_state == R_WAIT && r_r_wait != 8'd0) begin
            r_r_wait <= r_r_wait - 8'd1;
         end
         // Placed after the AR capture so a same-edge load advances past it.
         if (w_load) begin
            r_r_idx  <= w_load_idx + 1'b1;
            r_r_left <= w_load_left - 9'd1;
            r_rdata  <= (w_load_resp == RESP_OKAY) ? w_fwd_word : '0;
            r_rresp  <= w_load_resp;
            r_rlast  <= (w_load_left == 9'd1);
         end else if (w_r_next != R_DATA) begin
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
         end
      end
   end

   assign mem_arready = r_arready;
   assign mem_rvalid  = r_rvalid;
   assign mem_rdata   = r_rdata;
   assign mem_rresp   = r_rresp;
   assign mem_rlast   = r_rlast;

   // Byte-offset bits are ignored: only 32-bit aligned words are addressed.
   logic w_unused;
   assign w_unused = ^{mem_awaddr[1:0], mem_araddr[1:0]};

endmodule

// File: tb/tb_axi3_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi3_mem_responder
//   Randomized bench for axi3_mem_responder with a word-array reference model.
//   Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_axi3_mem_responder;

   localparam int          DEPTH  = 4096;
   localparam logic [31:0] BASE   = 32'h0;
   localparam int          RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_awvalid, mem_awready;
   logic [31:0] mem_awaddr;
   logic [7:0]  mem_awlen;
   logic [2:0]  mem_awsize;
   logic [1:0]  mem_awburst;
   logic        mem_wvalid, mem_wready, mem_wlast;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;
   logic [1:0]  mem_bresp;
   logic        mem_arvalid, mem_arready;
   logic [31:0] mem_araddr;
   logic [7:0]  mem_arlen;
   logic [2:0]  mem_arsize;
   logic [1:0]  mem_arburst;
   logic        mem_rvalid, mem_rready, mem_rlast;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;

   axi3_mem_responder #(.BIT_WIDTH(32), .ADDR_WIDTH(12), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
      .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
      .mem_rresp(mem_rresp), .mem_rlast(mem_rlast)
   );

   always #5 clk = ~clk;

   // Reference model: word contents plus a flag saying the word is fully known.
   logic [31:0] model_mem [0:DEPTH-1];
   bit          known     [0:DEPTH-1];
   logic [31:0] wr_data   [0:255];
   logic [3:0]  wr_strb   [0:255];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] off;
      off = addr - BASE;
      if (off >= 32'(DEPTH * 4))                          return 2'b11;
      if (size != 3'd2 || burst != 2'b01 || len > 8'd15) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int word_of(input logic [31:0] addr, input int beat);
      return (int'((addr - BASE) >> 2) + beat) % DEPTH;
   endfunction

   // Caller is on a falling edge; returns on the falling edge after the handshake.
   task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      int n = 0;
      mem_awvalid = 1'b1; mem_awaddr = a; mem_awlen = l; mem_awsize = s; mem_awburst = b;
      while (!mem_awready && n < 50) begin @(negedge clk); n++; end
      check("awready", 32'(mem_awready), 32'd1);
      @(negedge clk);
      mem_awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      int n = 0;
      mem_arvalid = 1'b1; mem_araddr = a; mem_arlen = l; mem_arsize = s; mem_arburst = b;
      while (!mem_arready && n < 50) begin @(negedge clk); n++; end
      check("arready", 32'(mem_arready), 32'd1);
      @(negedge clk);
      mem_arvalid = 1'b0;
   endtask

   // bad >= 0 flips wlast on that beat (early or missing last).
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int bad, input int b_delay);
      logic [1:0] er;
      int n;
      er = exp_resp(addr, len, size, burst);
      if (bad >= 0 && er == 2'b00) er = 2'b10;
      @(negedge clk);
      send_aw(addr, len, size, burst);
      check("wready_lat", 32'(mem_wready), 32'd1);
      for (int i = 0; i <= int'(len); i++) begin
         mem_wvalid = 1'b1; mem_wdata = wr_data[i]; mem_wstrb = wr_strb[i];
         mem_wlast  = (i == int'(len)) ^ (i == bad);
         n = 0;
         while (!mem_wready && n < 50) begin @(negedge clk); n++; end
         check("wready", 32'(mem_wready), 32'd1);
         @(negedge clk);
         if (exp_resp(addr, len, size, burst) == 2'b00) begin
            if (bad >= 0) known[word_of(addr, i)] = 1'b0;
            else begin
               for (int b = 0; b < 4; b++)
                  if (wr_strb[i][b]) model_mem[word_of(addr, i)][8*b +: 8] = wr_data[i][8*b +: 8];
               if (wr_strb[i] == 4'hF) known[word_of(addr, i)] = 1'b1;
            end
         end
      end
      mem_wvalid = 1'b0; mem_wlast = 1'b0;
      check("bvalid_lat", 32'(mem_bvalid), 32'd1);
      check("bresp", 32'(mem_bresp), 32'(er));
      for (int d = 0; d < b_delay; d++) begin
         @(negedge clk);
         check("bvalid_hold", 32'(mem_bvalid), 32'd1);
         check("bresp_hold", 32'(mem_bresp), 32'(er));
         check("awready_in_resp", 32'(mem_awready), 32'd0);
      end
      mem_bready = 1'b1;
      @(negedge clk);
      mem_bready = 1'b0;
      check("bvalid_drop", 32'(mem_bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_max);
      logic [1:0]  er;
      logic [31:0] want;
      int          lat, idx, s;
      bit          dchk;
      er = exp_resp(addr, len, size, burst);
      @(negedge clk);
      send_ar(addr, len, size, burst);
      lat = 1;
      while (!mem_rvalid && lat < 50) begin @(negedge clk); lat++; end
      check("rd_latency", 32'(lat), 32'(RD_LAT));
      for (int i = 0; i <= int'(len); i++) begin
         idx  = word_of(addr, i);
         want = (er == 2'b00) ? model_mem[idx] : 32'h0;
         dchk = (er != 2'b00) || known[idx];
         check("rvalid", 32'(mem_rvalid), 32'd1);
         check("rresp", 32'(mem_rresp), 32'(er));
         check("rlast", 32'(mem_rlast), 32'(i == int'(len)));
         if (dchk) check("rdata", mem_rdata, want);
         s = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
         for (int k = 0; k < s; k++) begin
            mem_rready = 1'b0;
            @(negedge clk);
            check("rvalid_stall", 32'(mem_rvalid), 32'd1);
            check("rlast_stall", 32'(mem_rlast), 32'(i == int'(len)));
            if (dchk) check("rdata_stall", mem_rdata, want);
         end
         mem_rready = 1'b1;
         @(negedge clk);
      end
      mem_rready = 1'b0;
      check("rvalid_end", 32'(mem_rvalid), 32'd0);
   endtask

   task automatic fill(input int len, input bit full_strb);
      for (int i = 0; i <= len; i++) begin
         wr_data[i] = $urandom;
         wr_strb[i] = (full_strb || $urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  sz;
      logic [1:0]  bu;
      int          n;
      for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; known[i] = 1'b0; end
      rst = 1'b1;
      mem_awvalid = 0; mem_awaddr = 0; mem_awlen = 0; mem_awsize = 0; mem_awburst = 0;
      mem_wvalid = 0; mem_wdata = 0; mem_wstrb = 0; mem_wlast = 0; mem_bready = 0;
      mem_arvalid = 0; mem_araddr = 0; mem_arlen = 0; mem_arsize = 0; mem_arburst = 0;
      mem_rready = 0;
      repeat (3) @(negedge clk);
      check("rst_awready", 32'(mem_awready), 32'd0);
      check("rst_wready", 32'(mem_wready), 32'd0);
      check("rst_bvalid", 32'(mem_bvalid), 32'd0);
      check("rst_arready", 32'(mem_arready), 32'd0);
      check("rst_rvalid", 32'(mem_rvalid), 32'd0);
      check("rst_resp", 32'({mem_bresp, mem_rresp, mem_rlast}), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_awready", 32'(mem_awready), 32'd1);
      check("idle_arready", 32'(mem_arready), 32'd1);

      // Single beat write/read, then a partial-strobe update.
      wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
      do_write(32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
      do_read(32'h10, 8'd0, 3'd2, 2'b01, 0);
      wr_data[0] = 32'h0000AB00; wr_strb[0] = 4'b0010;
      do_write(32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
      check("strb_model", model_mem[4], 32'hDEADABEF);
      do_read(32'h10, 8'd0, 3'd2, 2'b01, 0);

      // INCR burst read back with rready toggling.
      for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
      do_write(32'h100, 8'd3, 3'd2, 2'b01, -1, 0);
      do_read(32'h100, 8'd3, 3'd2, 2'b01, 2);

      // Out-of-range and unsupported-size bursts; word 0 must survive.
      wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
      do_write(32'h0, 8'd0, 3'd2, 2'b01, -1, 0);
      wr_data[0] = 32'hFFFFFFFF;
      do_write(BASE + 32'h4000, 8'd0, 3'd2, 2'b01, -1, 0);
      do_read(BASE + 32'h4000, 8'd0, 3'd2, 2'b01, 0);
      do_write(32'h0, 8'd0, 3'd1, 2'b01, -1, 0);
      do_read(32'h0, 8'd0, 3'd2, 2'b01, 0);

      // wlast framing errors: early on beat 0, and missing on a single beat.
      fill(1, 1'b1);
      do_write(32'h40, 8'd1, 3'd2, 2'b01, 0, 0);
      do_write(32'h48, 8'd0, 3'd2, 2'b01, 0, 0);

      // Index wrap at the top of the array.
      fill(3, 1'b1);
      do_write(32'h3FF8, 8'd3, 3'd2, 2'b01, -1, 1);
      do_read(32'h3FF8, 8'd3, 3'd2, 2'b01, 1);

      // Held write response while a 4-beat read completes.
      fill(3, 1'b1);
      do_write(32'h200, 8'd3, 3'd2, 2'b01, -1, 0);
      fill(0, 1'b1);
      fork
         do_write(32'h300, 8'd0, 3'd2, 2'b01, -1, 5);
         do_read(32'h200, 8'd3, 3'd2, 2'b01, 0);
      join

      // Read beat presented the cycle after a write to the same word: new data.
      wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
      do_write(32'h80, 8'd0, 3'd2, 2'b01, -1, 0);
      @(negedge clk);
      send_aw(32'h80, 8'd0, 3'd2, 2'b01);
      mem_wvalid = 1'b1; mem_wdata = 32'hCAFE1234; mem_wstrb = 4'hF; mem_wlast = 1'b1;
      mem_arvalid = 1'b1; mem_araddr = 32'h80; mem_arlen = 8'd0; mem_arsize = 3'd2; mem_arburst = 2'b01;
      check("fwd_wready", 32'(mem_wready), 32'd1);
      check("fwd_arready", 32'(mem_arready), 32'd1);
      @(negedge clk);
      mem_wvalid = 1'b0; mem_wlast = 1'b0; mem_arvalid = 1'b0;
      model_mem[32] = 32'hCAFE1234;
      check("fwd_rvalid", 32'(mem_rvalid), 32'd1);
      check("fwd_new_data", mem_rdata, model_mem[32]);
      mem_rready = 1'b1; mem_bready = 1'b1;
      @(negedge clk);
      mem_rready = 1'b0; mem_bready = 1'b0;
      check("fwd_done", 32'({mem_rvalid, mem_bvalid}), 32'd0);

      // Write landing while a beat is already presented: beat keeps old data.
      send_aw(32'h80, 8'd0, 3'd2, 2'b01);
      send_ar(32'h80, 8'd0, 3'd2, 2'b01);
      mem_wvalid = 1'b1; mem_wdata = 32'h5555AAAA; mem_wstrb = 4'hF; mem_wlast = 1'b1;
      check("same_cycle_old", mem_rdata, 32'hCAFE1234);
      @(negedge clk);
      mem_wvalid = 1'b0; mem_wlast = 1'b0;
      check("old_held", mem_rdata, 32'hCAFE1234);
      model_mem[32] = 32'h5555AAAA;
      mem_rready = 1'b1; mem_bready = 1'b1;
      @(negedge clk);
      mem_rready = 1'b0; mem_bready = 1'b0;
      do_read(32'h80, 8'd0, 3'd2, 2'b01, 0);

      // Reset on beat 3 of an 8-beat read.
      fill(7, 1'b1);
      do_write(32'h500, 8'd7, 3'd2, 2'b01, -1, 0);
      @(negedge clk);
      send_ar(32'h500, 8'd7, 3'd2, 2'b01);
      mem_rready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_beat3", mem_rdata, model_mem[word_of(32'h500, 2)]);
      rst = 1'b1; mem_rready = 1'b0;
      @(negedge clk);
      check("rst_mid_rvalid", 32'(mem_rvalid), 32'd0);
      check("rst_mid_arready", 32'(mem_arready), 32'd0);
      rst = 1'b0;
      n = 0;
      @(negedge clk);
      check("post_rst_arready", 32'(mem_arready), 32'd1);
      do_read(32'h500, 8'd7, 3'd2, 2'b01, 1);

      // Randomized traffic, including error bursts.
      for (int t = 0; t < 30; t++) begin
         a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
         l  = 8'($urandom_range(0, 7));
         sz = 3'd2;
         bu = 2'b01;
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0:       a  = a + 32'h4000 * 32'($urandom_range(1, 8));
               1:       sz = 3'($urandom_range(0, 1));
               2:       bu = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
               default: l  = 8'($urandom_range(16, 20));
            endcase
         end
         fill(int'(l), 1'b0);
         do_write(a, l, sz, bu, -1, int'($urandom_range(0, 2)));
         do_read(a, l, sz, bu, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
